down_timer: RTL

Loadable N-bit down-counting timer: the consuming side of the free-running up-counter tick scheme. Software or a sequencer loads a count, starts the timer, and receives a single-cycle `done` pulse at terminal count. Supports one-shot and periodic (auto-reload) modes, pause/resume, and an optional internal prescaler. Used for frame-interval, timeout and retransmit timing in the video-call datapath.

---
 rtl/down_timer.sv | 96 +++++++++
 1 files changed

// File: rtl/down_timer.sv
// down_timer: loadable N-bit down timer with one-shot/periodic modes, pause/resume and done pulse.
// Optional clock-enable prescaler enabled by defining DOWN_TIMER_PRESCALE_EN.
module down_timer #(
  parameter int N        = 8,
  parameter int PRESCALE = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         start,
  input  logic         stop,
  input  logic         periodic,
  input  logic         en,
  output logic [N-1:0] q,
  output logic         busy,
  output logic         min_tick,
  output logic         done
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;
  if (N < 2 || PRESCALE < 2) begin : g_bad_param
    $error("down_timer: N and PRESCALE must both be >= 2");
  end
  state_t       r_state, w_state;
  logic [N-1:0] r_q, w_q, r_reload, w_reload;
  logic         r_periodic, w_periodic, w_done, r_done;
  logic         w_step, w_adv;
  assign w_adv = (r_state == S_RUN) && en && !load && !stop;
`ifdef DOWN_TIMER_PRESCALE_EN
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] P_MAX = PW'(PRESCALE - 1);
  logic [PW-1:0] r_ps, w_ps;
  assign w_step = w_adv && (r_ps == P_MAX);
  always_comb begin
    w_ps = r_ps;
    if (load || (r_state == S_IDLE && start && r_q != '0))
      w_ps = '0;
    else if (w_adv)
      w_ps = (r_ps == P_MAX) ? '0 : r_ps + 1'b1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_ps <= '0;
    else       r_ps <= w_ps;
`else
  assign w_step = w_adv;
`endif
  always_comb begin
    w_state    = r_state;
    w_q        = r_q;
    w_reload   = r_reload;
    w_periodic = r_periodic;
    w_done     = 1'b0;
    if (load) begin
      w_q      = load_val;
      w_reload = load_val;
      w_state  = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (start && r_q != '0) begin
          w_periodic = periodic;
          w_state    = S_RUN;
        end
        S_RUN: if (stop) w_state = S_HOLD;
        else if (w_step) begin
          // terminal count reloads in periodic mode, otherwise ends the run
          if (r_q > N'(1)) w_q = r_q - 1'b1;
          else if (r_q == N'(1)) begin
            w_done  = 1'b1;
            w_q     = r_periodic ? r_reload : '0;
            w_state = r_periodic ? S_RUN : S_IDLE;
          end
        end
        S_HOLD: if (start) w_state = S_RUN;
        default: w_state = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state    <= S_IDLE;
      r_q        <= '0;
      r_reload   <= '0;
      r_periodic <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_q        <= w_q;
      r_reload   <= w_reload;
      r_periodic <= w_periodic;
      r_done     <= w_done;
    end
  assign q        = r_q;
  assign busy     = (r_state != S_IDLE);
  assign min_tick = (r_q == '0);
  assign done     = r_done;
endmodule
